// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the decode-side pipeline blocks.
//   - Major opcode constants (instr[6:0]).
//   - Default datapath width.
package rv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/operand_use_dec.sv
// Operand-use decoder: tells which register fields of an instruction are real.
// Ports:
//   opcode_i    instr[6:0]
//   uses_rs1_o  instruction reads rs1 (everything except LUI/AUIPC/JAL)
//   uses_rs2_o  instruction reads rs2 (BRANCH/STORE/OP)
//   has_rd_o    instruction writes rd (everything except BRANCH/STORE)
module operand_use_dec
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       has_rd_o
);

  always_comb begin
    uses_rs1_o = !((opcode_i == OPC_LUI) || (opcode_i == OPC_AUIPC) ||
                   (opcode_i == OPC_JAL));
    uses_rs2_o = (opcode_i == OPC_BRANCH) || (opcode_i == OPC_STORE) ||
                 (opcode_i == OPC_OP);
    has_rd_o   = !((opcode_i == OPC_BRANCH) || (opcode_i == OPC_STORE));
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-side operand fetch with writeback bypass, load-use hazard bubbles
// and the ID/EX pipeline register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_valid/id_ready               upstream handshake; id_instr, id_pc payload
//   rf_a1/rf_a2, rf_rd1/rf_rd2      register-file read addresses / data
//   wb_we/wb_rd/wb_data             writeback port (for same-cycle bypass)
//   flush                           redirect: kill ID and EX contents
//   ex_valid/ex_ready               downstream handshake; ex_* registered payload
//   stall_cnt                       saturating count of load-use bubbles
//
// Handshake: an upstream instruction transfers on a cycle where
// id_valid && id_ready. The EX register advances whenever ex_ready is high;
// with ex_ready low every EX field is held. id_ready is low during a
// load-use hazard, a flush or a downstream stall.
module operand_fetch_stage #(
  parameter int XLEN  = rv_pkg::XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  output logic [4:0]       rf_a1,
  output logic [4:0]       rf_a2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [31:0]      ex_instr,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [4:0]       ex_rd,
  output logic [CNT_W-1:0] stall_cnt
);
  import rv_pkg::*;

  logic [4:0]       rs1, rs2, rd;
  logic             uses_rs1, uses_rs2, has_rd;
  logic [XLEN-1:0]  op1, op2;
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt_d;

  logic             ex_valid_q;
  logic [31:0]      ex_instr_q;
  logic [XLEN-1:0]  ex_pc_q, ex_rs1_q, ex_rs2_q;
  logic [4:0]       ex_rd_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign rs1   = id_instr[19:15];
  assign rs2   = id_instr[24:20];
  assign rd    = id_instr[11:7];
  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  operand_use_dec u_dec (
    .opcode_i   (id_instr[6:0]),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .has_rd_o   (has_rd)
  );

  // x0 is forced to zero regardless of what the register file returns;
  // the nonzero test therefore also covers the wb_rd!=0 bypass condition.
  always_comb begin
    if (rs1 == 5'd0)                    op1 = '0;
    else if (wb_we && (wb_rd == rs1))   op1 = wb_data;
    else                                op1 = rf_rd1;
    if (rs2 == 5'd0)                    op2 = '0;
    else if (wb_we && (wb_rd == rs2))   op2 = wb_data;
    else                                op2 = rf_rd2;
  end

  // ex_rd_q is already 0 for instructions without rd, so a live load in EX
  // with ex_rd_q!=0 is a genuine producer.
  assign hazard = id_valid && ex_valid_q && (ex_instr_q[6:0] == OPC_LOAD) &&
                  (ex_rd_q != 5'd0) &&
                  ((uses_rs1 && (rs1 == ex_rd_q)) ||
                   (uses_rs2 && (rs2 == ex_rd_q)));

  assign id_ready = ex_ready && !hazard && !flush;

  assign stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_instr_q  <= '0;
      ex_pc_q     <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (!ex_ready) begin
      // hold everything
    end else if (hazard) begin
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= stall_cnt_d;
    end else if (id_valid) begin
      ex_valid_q <= 1'b1;
      ex_instr_q <= id_instr;
      ex_pc_q    <= id_pc;
      ex_rs1_q   <= op1;
      ex_rs2_q   <= op2;
      ex_rd_q    <= has_rd ? rd : 5'd0;
    end else begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_instr   = ex_instr_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs1_val = ex_rs1_q;
  assign ex_rs2_val = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, bypass, x0, load-use
// bubbles, stall hold, flush and asynchronous reset.
module tb_operand_fetch_stage;
  import rv_pkg::*;

  logic        clk, rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_instr, ex_pc, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rd;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  operand_fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_rd(ex_rd), .stall_cnt(stall_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // helpers
  function automatic logic [31:0] r_type(input logic [6:0] opc,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [6:0] opc,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] d1,
                       input logic [31:0] d2);
    id_valid = v;
    id_instr = instr;
    id_pc    = pc;
    rf_rd1   = d1;
    rf_rd2   = d2;
    #1;
  endtask

  logic [31:0] add_a, lw5, add_dep1, add_dep2, addi_ind, lui6, beq, hold_i;

  initial begin
    add_a    = r_type(OPC_OP, 5'd3, 5'd1, 5'd2);
    lw5      = i_type(OPC_LOAD, 5'd5, 5'd1, 12'd0);
    add_dep1 = r_type(OPC_OP, 5'd6, 5'd5, 5'd2);
    add_dep2 = r_type(OPC_OP, 5'd6, 5'd1, 5'd5);
    addi_ind = i_type(OPC_OPIMM, 5'd6, 5'd7, 12'd1);
    lui6     = {12'h000, 5'd5, 3'b000, 5'd6, OPC_LUI};   // rs1 field aliases x5
    beq      = r_type(OPC_BRANCH, 5'd9, 5'd1, 5'd2);
    hold_i   = r_type(OPC_OP, 5'd10, 5'd11, 5'd12);

    rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    id_valid = 1'b0; id_instr = 32'h0; id_pc = 32'h0;
    rf_rd1 = 32'h0; rf_rd2 = 32'h0;

    // reset
    tick(); tick();
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
    chk("rst_ex_instr", ex_instr, 32'd0);
    rst_n = 1'b1;

    // basic ADD x3,x1,x2
    drive(1'b1, add_a, 32'h100, 32'd5, 32'd7);
    chk("rf_a1", {27'b0, rf_a1}, 32'd1);
    chk("rf_a2", {27'b0, rf_a2}, 32'd2);
    chk("add_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("add_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("add_rs1", ex_rs1_val, 32'd5);
    chk("add_rs2", ex_rs2_val, 32'd7);
    chk("add_rd", {27'b0, ex_rd}, 32'd3);
    chk("add_pc", ex_pc, 32'h100);
    chk("add_instr", ex_instr, add_a);

    // bypass to rs1
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
    drive(1'b1, add_a, 32'h104, 32'h11, 32'h22);
    tick();
    chk("byp_rs1", ex_rs1_val, 32'hAA);
    chk("byp_rs1_other", ex_rs2_val, 32'h22);
    // write to x0 is never bypassed
    wb_rd = 5'd0;
    drive(1'b1, add_a, 32'h108, 32'h11, 32'h22);
    tick();
    chk("byp_x0_wb", ex_rs1_val, 32'h11);
    // bypass to rs2
    wb_rd = 5'd2; wb_data = 32'hBB;
    drive(1'b1, add_a, 32'h10C, 32'h11, 32'h22);
    tick();
    chk("byp_rs2", ex_rs2_val, 32'hBB);
    wb_we = 1'b0;
    // reading x0
    drive(1'b1, r_type(OPC_OP, 5'd4, 5'd0, 5'd2), 32'h110, 32'hFF, 32'h22);
    tick();
    chk("x0_read", ex_rs1_val, 32'd0);

    // idle cycle -> ex_valid drops
    drive(1'b0, add_a, 32'h114, 32'h0, 32'h0);
    tick();
    chk("idle_ex_valid", {31'b0, ex_valid}, 32'd0);

    // load-use on rs1
    drive(1'b1, lw5, 32'h200, 32'h0, 32'h0);
    tick();
    chk("lw_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("lw_ex_rd", {27'b0, ex_rd}, 32'd5);
    drive(1'b1, add_dep1, 32'h204, 32'h33, 32'h44);
    chk("lu1_id_ready", {31'b0, id_ready}, 32'd0);
    tick();
    chk("lu1_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu1_stall_cnt", stall_cnt, 32'd1);
    #1;
    chk("lu1_ready_after", {31'b0, id_ready}, 32'd1);
    tick();
    chk("lu1_capt_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu1_capt_instr", ex_instr, add_dep1);
    chk("lu1_capt_rd", {27'b0, ex_rd}, 32'd6);

    // load followed by independent ADDI -> no stall
    drive(1'b1, lw5, 32'h208, 32'h0, 32'h0);
    tick();
    drive(1'b1, addi_ind, 32'h20C, 32'h1, 32'h0);
    chk("ind_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("ind_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("ind_ex_rd", {27'b0, ex_rd}, 32'd6);
    chk("ind_stall_cnt", stall_cnt, 32'd1);

    // load-use on rs2
    drive(1'b1, lw5, 32'h210, 32'h0, 32'h0);
    tick();
    drive(1'b1, add_dep2, 32'h214, 32'h0, 32'h0);
    chk("lu2_id_ready", {31'b0, id_ready}, 32'd0);
    tick();
    chk("lu2_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu2_stall_cnt", stall_cnt, 32'd2);
    tick();
    chk("lu2_capt_instr", ex_instr, add_dep2);

    // load then LUI whose rs1 field aliases x5 -> no stall
    drive(1'b1, lw5, 32'h218, 32'h0, 32'h0);
    tick();
    drive(1'b1, lui6, 32'h21C, 32'h0, 32'h0);
    chk("lui_id_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("lui_ex_valid", {31'b0, ex_valid}, 32'd1);

    // branch has no rd
    drive(1'b1, beq, 32'h300, 32'h0, 32'h0);
    tick();
    chk("beq_ex_rd", {27'b0, ex_rd}, 32'd0);
    chk("beq_ex_valid", {31'b0, ex_valid}, 32'd1);

    // downstream stall: EX holds the branch for 3 cycles
    ex_ready = 1'b0;
    drive(1'b1, hold_i, 32'h304, 32'h55, 32'h66);
    for (int i = 0; i < 3; i++) begin
      chk("hold_id_ready", {31'b0, id_ready}, 32'd0);
      tick();
      chk("hold_ex_valid", {31'b0, ex_valid}, 32'd1);
      chk("hold_ex_instr", ex_instr, beq);
      chk("hold_ex_pc", ex_pc, 32'h300);
      chk("hold_stall_cnt", stall_cnt, 32'd2);
    end
    ex_ready = 1'b1;
    #1;
    chk("hold_release_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("hold_release_instr", ex_instr, hold_i);
    chk("hold_release_rs1", ex_rs1_val, 32'h55);

    // flush during a load-use hazard
    drive(1'b1, lw5, 32'h400, 32'h0, 32'h0);
    tick();
    flush = 1'b1;
    drive(1'b1, add_dep1, 32'h404, 32'h0, 32'h0);
    chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_stall_cnt", stall_cnt, 32'd2);

    // asynchronous reset with a live instruction in EX
    drive(1'b1, add_a, 32'h500, 32'h9, 32'h8);
    tick();
    chk("pre_arst_valid", {31'b0, ex_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_ex_pc", ex_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_arst_valid", {31'b0, ex_valid}, 32'd1);
    chk("post_arst_pc", ex_pc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
